exe_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EXE stage.
- Consumes the EXE-stage operands, funct3 and M-extension decode produced by the ID/EXE pipeline register.
- Returns the result to the EXE result mux.
- Holds the pipeline through md_stall while it works. md_stall is ORed into the same stall network as im_stall/dm_stall.

---
 rtl/exe_muldiv_if.sv | 28 ++
 rtl/exe_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if: handshake and data bundle between the EXE stage and the
// iterative multiply/divide unit.
//   master (EXE stage): drives start, funct3, src1, src2, hold, flush
//                       and receives md_stall, result_valid, result
//   slave  (md unit)  : the mirror image
interface exe_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            hold;
    logic            flush;
    logic            md_stall;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, src1, src2, hold, flush,
        input  md_stall, result_valid, result
    );

    modport slave (
        input  start, funct3, src1, src2, hold, flush,
        output md_stall, result_valid, result
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative RV32M multiply/divide unit for the EXE stage.
// Multiplies take one working cycle (result two cycles after start);
// divides use a radix-2 restoring loop of 32 cycles on operand magnitudes.
// Divide-by-zero and signed overflow can optionally finish immediately.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - exe_muldiv_if slave: start/funct3/src1/src2/hold/flush in,
//            md_stall/result_valid/result out
module exe_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int EARLY_DIV_EXIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    exe_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg;
    logic [1:0]      op_reg;          // funct3[1:0]; funct3[2] only steers the first transition
    logic [XLEN-1:0] a_reg;           // MUL: src1; DIV: dividend shifting out / quotient shifting in
    logic [XLEN-1:0] b_reg;           // MUL: src2; DIV: divisor magnitude
    logic [XLEN-1:0] rem_reg;
    logic [4:0]      counter_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            special_reg;
    logic [XLEN-1:0] special_val_reg;
    logic [XLEN-1:0] result_reg;

    // ---------------- start-cycle decode of the live operands ----------------
    logic            is_signed_in;
    logic            is_rem_in;
    logic            div_zero_in;
    logic            ovf_in;
    logic            special_in;
    logic [XLEN-1:0] special_val_in;
    logic [XLEN-1:0] abs1_in;
    logic [XLEN-1:0] abs2_in;

    always_comb begin
        is_signed_in   = ~bus.funct3[0];
        is_rem_in      = bus.funct3[1];
        div_zero_in    = (bus.src2 == '0);
        ovf_in         = is_signed_in && (bus.src1 == INT_MIN) && (bus.src2 == '1);
        special_in     = div_zero_in | ovf_in;
        if (div_zero_in)
            special_val_in = is_rem_in ? bus.src1 : '1;
        else
            special_val_in = is_rem_in ? '0 : INT_MIN;
        abs1_in = (is_signed_in && bus.src1[XLEN-1]) ? -bus.src1 : bus.src1;
        abs2_in = (is_signed_in && bus.src2[XLEN-1]) ? -bus.src2 : bus.src2;
    end

    // ---------------- multiply datapath (MUL state) ----------------
    // 33-bit extension decides signedness; widening both to 64 bits lets a
    // plain 64-bit multiply yield the correct low 64 bits of the product.
    logic              a_top;
    logic              b_top;
    logic [2*XLEN-1:0] a_wide;
    logic [2*XLEN-1:0] b_wide;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_final;

    always_comb begin
        a_top     = (op_reg != 2'b11) & a_reg[XLEN-1];
        b_top     = ~op_reg[1] & b_reg[XLEN-1];
        a_wide    = {{XLEN{a_top}}, a_reg};
        b_wide    = {{XLEN{b_top}}, b_reg};
        product   = a_wide * b_wide;
        mul_final = (op_reg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // ---------------- restoring divide step (DIV state) ----------------
    // rem_reg is always below the divisor, so the 33-bit difference's top
    // bit is a clean borrow flag.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] quo_signed;
    logic [XLEN-1:0] rem_signed;
    logic [XLEN-1:0] div_final;

    always_comb begin
        rem_shift  = {rem_reg, a_reg[XLEN-1]};
        diff       = rem_shift - {1'b0, b_reg};
        take       = ~diff[XLEN];
        rem_step   = take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_step   = {a_reg[XLEN-2:0], take};
        quo_signed = neg_q_reg ? -quo_step : quo_step;
        rem_signed = neg_r_reg ? -rem_step : rem_step;
        // Special cases that ran the full loop are overridden here because
        // the sign fix-up would corrupt the signed divide-by-zero result.
        if (special_reg)
            div_final = special_val_reg;
        else
            div_final = op_reg[1] ? rem_signed : quo_signed;
    end

    // ---------------- control and state ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_reg          <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            rem_reg         <= '0;
            counter_reg     <= '0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
            result_reg      <= '0;
        end else if (bus.flush) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg <= bus.funct3[1:0];
                        if (!bus.funct3[2]) begin
                            a_reg     <= bus.src1;
                            b_reg     <= bus.src2;
                            state_reg <= MUL;
                        end else begin
                            a_reg           <= abs1_in;
                            b_reg           <= abs2_in;
                            rem_reg         <= '0;
                            counter_reg     <= '0;
                            neg_q_reg       <= is_signed_in & (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
                            neg_r_reg       <= is_signed_in & bus.src1[XLEN-1];
                            special_reg     <= special_in;
                            special_val_reg <= special_val_in;
                            if ((EARLY_DIV_EXIT != 0) && special_in) begin
                                result_reg <= special_val_in;
                                state_reg  <= DONE;
                            end else begin
                                state_reg <= DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    result_reg <= mul_final;
                    state_reg  <= DONE;
                end
                DIV: begin
                    a_reg       <= quo_step;
                    rem_reg     <= rem_step;
                    counter_reg <= counter_reg + 5'd1;
                    if (counter_reg == 5'd31) begin
                        result_reg <= div_final;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    // The pipeline advances in the cycle hold is low, so the
                    // next M op is picked up from IDLE one cycle later.
                    if (!bus.hold)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.md_stall     = ((state_reg == IDLE) && bus.start && !bus.flush)
                              || (state_reg == MUL) || (state_reg == DIV);
    assign bus.result_valid = (state_reg == DONE);
    assign bus.result       = result_reg;
endmodule
